// File: rtl/dac_ds_multi.sv
// Multi-channel first-order delta-sigma DAC with valid/ready sample handshake and soft-mute gain ramp.
// Define DAC_DITHER_EN to add a shared 16-bit LFSR dither bit to every channel's modulator sum.
module dac_ds_multi #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8,
  parameter int GB       = 4,
  parameter int RAMP_DIV = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      valid,
  output logic                      ready,
  input  logic                      mute,
  output logic                      muted,
  output logic [CHANNELS-1:0]       q
);

  localparam int PW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int PWID = WIDTH + GB + 2;
  localparam logic [WIDTH-1:0] MID  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [GB:0]      GMAX = {1'b1, {GB{1'b0}}};
  localparam logic [PW-1:0]    LAST = PW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {MUTED, UP, RUN, DOWN} state_t;

  // Offset-binary sample scaled about midscale; the product always fits, so the result never overflows.
  function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] s, input logic [GB:0] g);
    logic signed [WIDTH:0]  v;
    logic signed [PWID-1:0] vx;
    logic signed [PWID-1:0] gx;
    logic signed [PWID-1:0] p;
    v     = $signed({1'b0, s}) - $signed({1'b0, MID});
    vx    = PWID'(v);
    gx    = PWID'($signed({1'b0, g}));
    p     = vx * gx;
    scale = MID + WIDTH'(p >>> GB);
  endfunction

  function automatic logic [GB:0] gain_inc(input logic [GB:0] g);
    gain_inc = (g == GMAX) ? g : g + 1'b1;
  endfunction

  function automatic logic [GB:0] gain_dec(input logic [GB:0] g);
    gain_dec = (g == '0) ? g : g - 1'b1;
  endfunction

  logic                      pending;
  logic [CHANNELS*WIDTH-1:0] pend_p0;
  logic [CHANNELS*WIDTH-1:0] active_p0;
  logic [CHANNELS*WIDTH-1:0] sample_p0;
  logic [PW-1:0]             presc;
  logic                      step;
  logic [GB:0]               gain;
  state_t                    state;
  state_t                    tgt;
  logic                      dith;

  assign ready = ~pending;

  // Sample handshake: one holding register, handed to all channels together on a ce tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending   <= 1'b0;
      pend_p0   <= {CHANNELS{MID}};
      active_p0 <= {CHANNELS{MID}};
    end else if (ce && pending) begin
      active_p0 <= pend_p0;
      pending   <= 1'b0;
    end else if (valid && !pending) begin
      pend_p0 <= d;
      pending <= 1'b1;
    end
  end

  // A sample being handed over on this tick is already the one the modulators see.
  assign sample_p0 = pending ? pend_p0 : active_p0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (ce) begin
      presc <= (presc == LAST) ? '0 : presc + 1'b1;
    end
  end

  assign step = ce && (presc == LAST);

  always_comb begin
    tgt = state;
    case (state)
      MUTED:   if (!mute) tgt = UP;
      UP:      if (mute)  tgt = DOWN;
      RUN:     if (mute)  tgt = DOWN;
      DOWN:    if (!mute) tgt = UP;
      default: tgt = MUTED;
    endcase
  end

  // Direction change takes effect first; a coincident step then moves gain in the new direction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= MUTED;
      gain  <= '0;
      muted <= 1'b1;
    end else begin
      state <= tgt;
      muted <= (tgt == MUTED);
      if (step && tgt == UP) begin
        gain <= gain_inc(gain);
        if (gain_inc(gain) == GMAX) state <= RUN;
      end else if (step && tgt == DOWN) begin
        gain <= gain_dec(gain);
        if (gain_dec(gain) == '0) begin
          state <= MUTED;
          muted <= 1'b1;
        end
      end
    end
  end

`ifdef DAC_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr <= 16'hACE1;
    end else if (ce) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign dith = lfsr[0];
`else
  assign dith = 1'b0;
`endif

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [WIDTH-1:0] e_p0;
    logic [WIDTH:0]   sum_p0;
    logic [WIDTH-1:0] acc_p1;
    logic             q_p1;

    assign e_p0   = scale(sample_p0[ch*WIDTH +: WIDTH], gain);
    assign sum_p0 = {1'b0, acc_p1} + {1'b0, e_p0} + {{WIDTH{1'b0}}, dith};

    // Stage p0 -> p1: accumulator and carry-out register feeding the output pin.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        acc_p1 <= MID;
        q_p1   <= 1'b0;
      end else if (ce) begin
        acc_p1 <= sum_p0[WIDTH-1:0];
        q_p1   <= sum_p0[WIDTH];
      end
    end

    assign q[ch] = q_p1;
  end

endmodule

// File: tb/tb_dac_ds_multi.sv
// Self-checking bench for dac_ds_multi: vector table, directed density/ramp/reset sequences,
// and randomized traffic compared tick-by-tick against an arithmetic reference model.
module tb_dac_ds_multi;
  localparam int CH   = 2;
  localparam int W    = 8;
  localparam int GB   = 4;
  localparam int RD   = 1;
  localparam int MIDV = 1 << (W - 1);
  localparam int GMX  = 1 << GB;
  localparam int S_MUTED = 0, S_UP = 1, S_RUN = 2, S_DOWN = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            ce;
  logic [CH*W-1:0] d;
  logic            valid;
  logic            ready;
  logic            mute;
  logic            muted;
  logic [CH-1:0]   q;

  int errors = 0;
  int checks = 0;
  int cnt[CH];

  int m_pending, m_presc, m_gain, m_state;
  int m_pend[CH];
  int m_act[CH];
  int m_acc[CH];
  int m_q[CH];

  typedef struct {
    logic            ce;
    logic            valid;
    logic            mute;
    logic [CH*W-1:0] d;
    logic            exp_ready;
    logic            exp_muted;
  } vec_t;

  vec_t tbl[10];

  always #5 clock = ~clock;

  dac_ds_multi #(.CHANNELS(CH), .WIDTH(W), .GB(GB), .RAMP_DIV(RD)) dut (
    .clock(clock), .reset(reset), .ce(ce), .d(d), .valid(valid),
    .ready(ready), .mute(mute), .muted(muted), .q(q)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int p, input int dv);
    if (p >= 0) return p / dv;
    return -((-p + dv - 1) / dv);
  endfunction

  task automatic model_reset();
    m_pending = 0;
    m_presc   = 0;
    m_gain    = 0;
    m_state   = S_MUTED;
    for (int c = 0; c < CH; c++) begin
      m_pend[c] = MIDV;
      m_act[c]  = MIDV;
      m_acc[c]  = MIDV;
      m_q[c]    = 0;
    end
  endtask

  // Next state of the whole block from the current inputs, in plain integer arithmetic.
  task automatic model_step();
    int src, e, s, dirn;
    bit stp;
    if (ce) begin
      for (int c = 0; c < CH; c++) begin
        src      = m_pending ? m_pend[c] : m_act[c];
        e        = MIDV + floor_div((src - MIDV) * m_gain, GMX);
        s        = m_acc[c] + e;
        m_q[c]   = (s >= (1 << W)) ? 1 : 0;
        m_acc[c] = s % (1 << W);
      end
    end
    stp = ce && (m_presc == RD - 1);
    if (ce) m_presc = (m_presc + 1) % RD;
    if (ce && m_pending) begin
      for (int c = 0; c < CH; c++) m_act[c] = m_pend[c];
      m_pending = 0;
    end else if (valid && !m_pending) begin
      for (int c = 0; c < CH; c++) m_pend[c] = int'(d[c*W +: W]);
      m_pending = 1;
    end
    if (mute && m_state != S_MUTED) dirn = -1;
    else if (!mute && m_state != S_RUN) dirn = 1;
    else dirn = 0;
    if (dirn == 1) begin
      m_state = S_UP;
      if (stp) begin
        m_gain = (m_gain + 1 > GMX) ? GMX : m_gain + 1;
        if (m_gain == GMX) m_state = S_RUN;
      end
    end else if (dirn == -1) begin
      m_state = S_DOWN;
      if (stp) begin
        m_gain = (m_gain - 1 < 0) ? 0 : m_gain - 1;
        if (m_gain == 0) m_state = S_MUTED;
      end
    end
  endtask

  task automatic tick();
    logic [CH-1:0] eq;
    model_step();
    @(posedge clock);
    #1;
    for (int c = 0; c < CH; c++) eq[c] = m_q[c][0];
    chk("model_q", q, eq);
    chk("model_ready", ready, m_pending ? 0 : 1);
    chk("model_muted", muted, (m_state == S_MUTED) ? 1 : 0);
    for (int c = 0; c < CH; c++) cnt[c] += q[c];
  endtask

  // Entered and left at posedge+1; reset is asserted between edges and checked before any edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk({tag, "_q"}, q, 0);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_muted"}, muted, 1);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic clear_cnt();
    for (int c = 0; c < CH; c++) cnt[c] = 0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h5678, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 16'h5678, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 16'h9ABC, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 16'hDEF0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};

    reset = 1'b1; ce = 1'b1; valid = 1'b0; mute = 1'b1; d = '0;
    clear_cnt();
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("por_q", q, 0);
    chk("por_ready", ready, 1);
    chk("por_muted", muted, 1);
    @(posedge clock);
    #1 reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      ce = tbl[i].ce; valid = tbl[i].valid; mute = tbl[i].mute; d = tbl[i].d;
      tick();
      chk($sformatf("tbl%0d_ready", i), ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_muted", i), muted, tbl[i].exp_muted);
    end

    ce = 1'b1; valid = 1'b0; mute = 1'b0;
    repeat (16) tick();
    chk("ramp_up_muted", muted, 0);
    d = {8'h40, 8'hC0}; valid = 1'b1;
    tick();
    valid = 1'b0;
    clear_cnt();
    repeat (256) tick();
    chk("dens_c0_ch0", cnt[0], 192);
    chk("dens_c0_ch1", cnt[1], 64);

    d = {8'hFF, 8'h00}; valid = 1'b1;
    tick();
    valid = 1'b0;
    clear_cnt();
    repeat (256) tick();
    chk("dens_zero_ch0", cnt[0], 0);
    chk("dens_full_ch1", cnt[1], 255);

    ce = 1'b0; valid = 1'b1; d = {8'h00, 8'hFF};
    tick();
    chk("hs_first_ready", ready, 0);
    d = {8'hFF, 8'h00};
    tick();
    chk("hs_second_ready", ready, 0);
    valid = 1'b0; ce = 1'b1;
    clear_cnt();
    tick();
    chk("hs_after_ce_ready", ready, 1);
    repeat (255) tick();
    chk("hs_kept_ch0", cnt[0], 255);
    chk("hs_kept_ch1", cnt[1], 0);

    async_reset("rst_a");
    ce = 1'b1; mute = 1'b0;
    repeat (5) tick();
    mute = 1'b1;
    repeat (4) tick();
    chk("down_4_muted", muted, 0);
    tick();
    chk("down_5_muted", muted, 1);
    clear_cnt();
    repeat (256) tick();
    chk("mute_dens_ch0", cnt[0], 128);
    chk("mute_dens_ch1", cnt[1], 128);

    mute = 1'b0;
    repeat (20) tick();
    chk("run_muted", muted, 0);
    ce = 1'b0; valid = 1'b1; d = {8'hFF, 8'hFF};
    tick();
    chk("run_pending_ready", ready, 0);
    valid = 1'b0;
    async_reset("rst_b");
    ce = 1'b1; mute = 1'b1;
    tick();
    chk("post_rst_q1", q, 2'b11);
    tick();
    chk("post_rst_q2", q, 2'b00);

    for (int i = 0; i < 3000; i++) begin
      ce    = ($urandom_range(0, 9) < 7);
      valid = ($urandom_range(0, 3) == 0);
      d     = CH*W'($urandom);
      if ($urandom_range(0, 39) == 0) mute = ~mute;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
